// File: rtl/button_pkg.sv
// Shared definitions for the button front end: channel state encoding and
// counter sizing helpers.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMING    = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    RELEASING = 3'd4
  } btn_state_t;

  // Bits needed to hold every value 0..max_value (never less than one bit).
  function automatic int counter_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, polarity normalisation,
// debounce/auto-repeat FSM and the registered enable/pressed outputs.
module button_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic enable,
  output logic pressed
);

  localparam int CNT_W = counter_width(DEBOUNCE_CYCLES);
  localparam int RPT_W = counter_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
  localparam logic RELEASED_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic sync1_reg, sync2_reg;
  logic p;

  btn_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RPT_W-1:0] rpt_reg, rpt_next;
  logic [RPT_W-1:0] rpt_target, rpt_inc;
  logic from_repeat_reg, from_repeat_next;
  logic enable_reg, enable_next;
  logic pressed_reg, pressed_next;

  // Synchroniser; reset preloads the released level so a held pin re-qualifies.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg <= RELEASED_LEVEL;
      sync2_reg <= RELEASED_LEVEL;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
    end
  end

  assign p = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  // Repeat target of the current (or interrupted) hold phase and saturating increment.
  always_comb begin
    rpt_target = RPT_DELAY;
    if (state_reg == REPEAT || (state_reg == RELEASING && from_repeat_reg)) begin
      rpt_target = RPT_PERIOD;
    end
    rpt_inc = (rpt_reg >= rpt_target) ? rpt_target : rpt_reg + RPT_W'(1);
  end

  // FSM state and counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rpt_reg         <= '0;
      from_repeat_reg <= 1'b0;
      enable_reg      <= 1'b0;
      pressed_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      rpt_reg         <= rpt_next;
      from_repeat_reg <= from_repeat_next;
      enable_reg      <= enable_next;
      pressed_reg     <= pressed_next;
    end
  end

  // Next-state logic. A repeat pulse is held off for one cycle if enable is
  // already high, so enable can never be asserted on two consecutive cycles;
  // rpt stays saturated meanwhile and the pulse follows on the next cycle.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    rpt_next         = rpt_reg;
    from_repeat_next = from_repeat_reg;
    enable_next      = 1'b0;
    pressed_next     = pressed_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (p) begin
          state_next = ARMING;
          cnt_next   = CNT_W'(1);
        end
      end
      ARMING: begin
        if (!p) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_DONE) begin
          state_next       = HELD;
          enable_next      = 1'b1;
          pressed_next     = 1'b1;
          rpt_next         = '0;
          cnt_next         = '0;
          from_repeat_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HELD, REPEAT: begin
        if (!p) begin
          state_next       = RELEASING;
          cnt_next         = CNT_W'(1);
          from_repeat_next = (state_reg == REPEAT);
        end else if (repeat_en && rpt_inc == rpt_target && !enable_reg) begin
          state_next  = REPEAT;
          enable_next = 1'b1;
          rpt_next    = '0;
        end else begin
          rpt_next = rpt_inc;
        end
      end
      RELEASING: begin
        rpt_next = rpt_inc;
        if (p) begin
          state_next = from_repeat_reg ? REPEAT : HELD;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_DONE) begin
          state_next   = IDLE;
          pressed_next = 1'b0;
          cnt_next     = '0;
          rpt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        rpt_next     = '0;
        pressed_next = 1'b0;
      end
    endcase
  end

  assign enable  = enable_reg;
  assign pressed = pressed_reg;

endmodule

// File: rtl/button_pulse_array.sv
// Multi-channel button front end: one independent debounce/repeat channel
// per pin, with the global repeat enable fanned out to all of them.
module button_pulse_array
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button,
  input  logic                   repeat_en,
  output logic [NUM_BUTTONS-1:0] enable,
  output logic [NUM_BUTTONS-1:0] pressed
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi = gi + 1) begin : g_channel
      button_channel #(
        .ACTIVE_LOW      (ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_channel (
        .clock     (clock),
        .reset     (reset),
        .button    (button[gi]),
        .repeat_en (repeat_en),
        .enable    (enable[gi]),
        .pressed   (pressed[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_pulse_array.sv
// Bench for button_pulse_array: directed scenarios with literal expectations
// plus randomized pin activity, all checked each cycle against a run-length
// debounce / hold-time repeat model.
module tb_button_pulse_array;

  localparam int NB = 4;
  localparam int AL = 1;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          repeat_en;
  logic [NB-1:0] button;
  logic [NB-1:0] enable;
  logic [NB-1:0] pressed;

  button_pulse_array #(
    .NUM_BUTTONS     (NB),
    .ACTIVE_LOW      (AL),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button    (button),
    .repeat_en (repeat_en),
    .enable    (enable),
    .pressed   (pressed)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit log_pulses = 1'b1;

  // Observed pulses (channel, edge number) for literal timing checks.
  int pulse_ch[$];
  int pulse_edge[$];

  // Model state: pin delay line, accepted level, length of the current run of
  // samples disagreeing with it, hold time since the last pulse.
  logic [NB-1:0] dly1, dly2;
  bit m_level    [NB];
  int m_run      [NB];
  int m_since    [NB];
  bit m_repeated [NB];
  bit m_pulse    [NB];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int count_pulses(input int ch, input int lo, input int hi);
    int n = 0;
    foreach (pulse_ch[k]) begin
      if (pulse_ch[k] == ch && pulse_edge[k] >= lo && pulse_edge[k] <= hi) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model and per-cycle compare.
  initial begin
    logic [NB-1:0] exp_en, exp_pr;
    bit p, prev;
    int target;
    forever begin
      @(posedge clock);
      edge_cnt++;
      if (!reset) begin
        dly1 = (AL != 0) ? '1 : '0;
        dly2 = dly1;
        for (int ch = 0; ch < NB; ch++) begin
          m_level[ch] = 0; m_run[ch] = 0; m_since[ch] = 0;
          m_repeated[ch] = 0; m_pulse[ch] = 0;
        end
      end else begin
        for (int ch = 0; ch < NB; ch++) begin
          p = (AL != 0) ? ~dly2[ch] : dly2[ch];
          prev = m_pulse[ch];
          m_pulse[ch] = 0;
          if (!m_level[ch]) begin
            if (p) begin
              m_run[ch]++;
              if (m_run[ch] == DB + 1) begin
                m_level[ch] = 1; m_run[ch] = 0; m_pulse[ch] = 1;
                m_since[ch] = 0; m_repeated[ch] = 0;
              end
            end else begin
              m_run[ch] = 0;
            end
          end else begin
            target = m_repeated[ch] ? RP : RD;
            if (m_run[ch] == 0 && p) begin
              m_since[ch] = imin(m_since[ch] + 1, target);
              if (repeat_en && m_since[ch] == target && !prev) begin
                m_pulse[ch] = 1; m_since[ch] = 0; m_repeated[ch] = 1;
              end
            end else if (m_run[ch] == 0) begin
              m_run[ch] = 1;
            end else begin
              m_since[ch] = imin(m_since[ch] + 1, target);
              if (!p) begin
                m_run[ch]++;
                if (m_run[ch] == DB + 1) begin
                  m_level[ch] = 0; m_run[ch] = 0;
                end
              end else begin
                m_run[ch] = 0;
              end
            end
          end
        end
        dly2 = dly1;
        dly1 = button;
      end
      #1;
      for (int ch = 0; ch < NB; ch++) begin
        exp_en[ch] = m_pulse[ch];
        exp_pr[ch] = m_level[ch];
        if (enable[ch]) begin
          pulse_ch.push_back(ch);
          pulse_edge.push_back(edge_cnt);
          if (log_pulses) $display("pulse ch=%0d edge=%0d", ch, edge_cnt);
        end
      end
      check("model_enable", int'(enable), int'(exp_en));
      check("model_pressed", int'(pressed), int'(exp_pr));
    end
  end

  // Stimulus and literal expectations.
  initial begin
    int e0, e1;
    reset = 1'b0;
    button = '0;
    repeat_en = 1'b0;

    // 1. Reset with every pin pressed, then release reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_enable", int'(enable), 0);
      check("reset_pressed", int'(pressed), 0);
    end
    reset = 1'b1;
    e0 = edge_cnt + 1;
    wait_neg(6);
    check("t1_before_pulse", int'(enable), 0);
    wait_neg(1);
    check("t1_pulse_all", int'(enable), 4'b1111);
    check("t1_pressed_all", int'(pressed), 4'b1111);
    check("t1_pulse_edge", count_pulses(0, e0 + 6, e0 + 6), 1);
    wait_neg(1);
    check("t1_single_cycle", int'(enable), 0);
    button = '1;
    wait_neg(10);
    check("t1_released", int'(pressed), 0);

    // 2. Clean press on channel 0.
    button[0] = 1'b0;
    e0 = edge_cnt + 1;
    wait_neg(10);
    check("t2_pulse_at_6", count_pulses(0, e0 + 6, e0 + 6), 1);
    check("t2_one_pulse", count_pulses(0, e0, edge_cnt), 1);
    check("t2_pressed", int'(pressed[0]), 1);
    button[0] = 1'b1;
    wait_neg(10);
    check("t2_released", int'(pressed[0]), 0);

    // 3. Bounce on channel 1.
    e0 = edge_cnt + 1;
    for (int k = 0; k < 10; k++) begin
      button[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
      wait_neg(2);
    end
    button[1] = 1'b1;
    wait_neg(10);
    check("t3_no_pulse", count_pulses(1, e0, edge_cnt), 0);
    check("t3_not_pressed", int'(pressed[1]), 0);

    // 4. Auto-repeat on channel 2, held 50 cycles.
    repeat_en = 1'b1;
    button[2] = 1'b0;
    e0 = edge_cnt + 1;
    wait_neg(50);
    button[2] = 1'b1;
    wait_neg(15);
    check("t4_first", count_pulses(2, e0 + 6, e0 + 6), 1);
    for (int t = 26; t <= 51; t += 5) begin
      check("t4_repeat", count_pulses(2, e0 + t, e0 + t), 1);
    end
    check("t4_total", count_pulses(2, e0, edge_cnt), 7);
    check("t4_after_release", count_pulses(2, e0 + 52, edge_cnt), 0);
    repeat_en = 1'b0;

    // 5. Simultaneous presses, then a short release glitch on channel 0.
    button[0] = 1'b0;
    button[3] = 1'b0;
    wait_neg(7);
    check("t5_simultaneous", int'(enable), 4'b1001);
    e0 = edge_cnt;
    wait_neg(3);
    button[0] = 1'b1;
    wait_neg(2);
    button[0] = 1'b0;
    wait_neg(10);
    check("t5_glitch_no_pulse", count_pulses(0, e0 + 1, edge_cnt), 0);
    check("t5_still_pressed", int'(pressed[0]), 1);
    button = '1;
    wait_neg(10);

    // 6. Reset while channel 2 is repeating, pin kept held.
    repeat_en = 1'b1;
    button[2] = 1'b0;
    wait_neg(30);
    reset = 1'b0;
    wait_neg(1);
    check("t6_cleared_enable", int'(enable), 0);
    check("t6_cleared_pressed", int'(pressed), 0);
    reset = 1'b1;
    e1 = edge_cnt + 1;
    wait_neg(12);
    check("t6_fresh_pulse", count_pulses(2, e1 + 6, e1 + 6), 1);
    check("t6_single_pulse", count_pulses(2, e1, edge_cnt), 1);
    repeat_en = 1'b0;
    button = '1;
    wait_neg(10);

    // Randomized activity: long holds, bounces, repeat_en toggling, rare resets.
    log_pulses = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if ($urandom_range(0, 99) < 6) button[ch] = ~button[ch];
      end
      if ($urandom_range(0, 99) < 2) repeat_en = ~repeat_en;
      reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      wait_neg(1);
    end
    reset = 1'b1;
    wait_neg(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
